// File: rtl/cell_cmd_parser.sv
// Byte-stream packet parser (A5, opcode, args) driving cell writes and frame commits; CELL_CMD_CHECKSUM_EN adds a trailing XOR byte.
// Latency: execution starts the cycle after the final byte; rx_ready drops for the whole EXEC phase (2 cycles per cell write).
module cell_cmd_parser #(
  parameter int WIDTH    = 16,
  parameter int HEIGHT   = 12,
  parameter int B_WIDTH  = 4,
  parameter int B_HEIGHT = 4,
  parameter int B_VGA    = 4
) (
  input  logic                  vclock,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [3*B_VGA-1:0]    cell_rgb,
  output logic [B_WIDTH-1:0]    cell_x,
  output logic [B_HEIGHT-1:0]   cell_y,
  output logic                  cell_en,
  output logic                  update,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            err_count
);

  localparam logic [7:0] HDR    = 8'hA5;
  localparam logic [7:0] OP_SET = 8'h01;
  localparam logic [7:0] OP_UPD = 8'h02;
  localparam logic [7:0] OP_FIL = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_ARG, S_CHK, S_EXEC} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            op_q, op_d;
  logic [4:0][7:0]       arg_q, arg_d, args_c;
  logic                  phase_q, phase_d;
  logic [B_WIDTH-1:0]    x_q, x_d;
  logic [B_HEIGHT-1:0]   y_q, y_d;
  logic [3*B_VGA-1:0]    rgb_q, rgb_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  run_q;
  logic                  acc;
  logic                  start;
  logic [2:0]            last_idx;
  logic                  unused_args;
`ifdef CELL_CMD_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign rx_ready    = run_q && (state_q != S_EXEC);
  assign busy        = (state_q == S_EXEC);
  assign cell_en     = busy && phase_q && (op_q != OP_UPD);
  assign update      = busy && (op_q == OP_UPD);
  assign err         = err_q;
  assign err_count   = err_cnt_q;
  assign cell_x      = x_q;
  assign cell_y      = y_q;
  assign cell_rgb    = rgb_q;
  assign acc         = rx_valid && rx_ready;
  assign last_idx    = (op_q == OP_SET) ? 3'd4 : 3'd2;
  assign unused_args = ^args_c;

  // Argument view including the byte being accepted, so execution can start on the same edge.
  always_comb begin
    args_c = arg_q;
    if (state_q == S_ARG) args_c[cnt_q] = rx_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    arg_d   = arg_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    rgb_d   = rgb_q;
    err_d   = 1'b0;
    start   = 1'b0;
`ifdef CELL_CMD_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: if (acc && rx_data == HDR) state_d = S_OPC;
      S_OPC: if (acc) begin
        op_d  = rx_data;
        cnt_d = 3'd0;
`ifdef CELL_CMD_CHECKSUM_EN
        csum_d = rx_data;
`endif
        if (rx_data == OP_SET || rx_data == OP_FIL) begin
          state_d = S_ARG;
        end else if (rx_data == OP_UPD) begin
`ifdef CELL_CMD_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_EXEC;
`endif
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ARG: if (acc) begin
        arg_d = args_c;
`ifdef CELL_CMD_CHECKSUM_EN
        csum_d = csum_q ^ rx_data;
`endif
        if (cnt_q == last_idx) begin
`ifdef CELL_CMD_CHECKSUM_EN
          state_d = S_CHK;
`else
          start   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`ifdef CELL_CMD_CHECKSUM_EN
      S_CHK: if (acc) begin
        if (rx_data != csum_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          start = 1'b1;
        end
      end
`endif
      S_EXEC: begin
        if (op_q == OP_UPD) begin
          state_d = S_IDLE;
        end else if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (op_q == OP_SET ||
              (x_q == B_WIDTH'(WIDTH-1) && y_q == B_HEIGHT'(HEIGHT-1))) begin
            state_d = S_IDLE;
          end else if (x_q == B_WIDTH'(WIDTH-1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      phase_d = 1'b0;
      if (op_q == OP_UPD) begin
        state_d = S_EXEC;
      end else if (op_q == OP_SET &&
                   ({24'd0, args_c[0]} >= 32'(WIDTH) || {24'd0, args_c[1]} >= 32'(HEIGHT))) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else if (op_q == OP_SET) begin
        state_d = S_EXEC;
        x_d     = args_c[0][B_WIDTH-1:0];
        y_d     = args_c[1][B_HEIGHT-1:0];
        rgb_d   = {args_c[2][B_VGA-1:0], args_c[3][B_VGA-1:0], args_c[4][B_VGA-1:0]};
      end else begin
        state_d = S_EXEC;
        x_d     = '0;
        y_d     = '0;
        rgb_d   = {args_c[0][B_VGA-1:0], args_c[1][B_VGA-1:0], args_c[2][B_VGA-1:0]};
      end
    end

    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      phase_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      run_q     <= 1'b0;
`ifdef CELL_CMD_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      phase_q   <= phase_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      run_q     <= 1'b1;
`ifdef CELL_CMD_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_cell_cmd_parser.sv
// Directed bench for cell_cmd_parser: packet sequences with hand-computed expectations.
module tb_cell_cmd_parser;
  logic        vclock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [11:0] cell_rgb;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic        cell_en, update, busy, err;
  logic [7:0]  err_count;

  int passed = 0;
  int total  = 0;

  int en_cnt, upd_cnt, err_pulses, busy_cnt, dbl, unstable, order_bad, rdy_bad;
  int exp_x, exp_y;
  logic [11:0] exp_rgb;
  logic fill_mode;
  logic prev_en;
  logic [3:0] px, py;
  logic [11:0] prgb;

  always #5 vclock = ~vclock;

  cell_cmd_parser #(.WIDTH(16), .HEIGHT(12), .B_WIDTH(4), .B_HEIGHT(4), .B_VGA(4)) dut (
    .vclock(vclock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cell_rgb(cell_rgb), .cell_x(cell_x), .cell_y(cell_y),
    .cell_en(cell_en), .update(update), .busy(busy), .err(err), .err_count(err_count)
  );

  always @(negedge vclock) begin
    if (cell_en) begin
      en_cnt++;
      if (prev_en) dbl++;
      if (cell_x !== px || cell_y !== py || cell_rgb !== prgb) unstable++;
      if (fill_mode) begin
        if (cell_x !== exp_x[3:0] || cell_y !== exp_y[3:0] || cell_rgb !== exp_rgb) order_bad++;
        if (exp_x == 15) begin exp_x = 0; exp_y++; end else exp_x++;
      end
    end
    if (update) upd_cnt++;
    if (err) err_pulses++;
    if (busy) busy_cnt++;
    if (busy && rx_ready) rdy_bad++;
    prev_en = cell_en;
    px = cell_x; py = cell_y; prgb = cell_rgb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    en_cnt = 0; upd_cnt = 0; err_pulses = 0; busy_cnt = 0;
    dbl = 0; unstable = 0; order_bad = 0; rdy_bad = 0;
    exp_x = 0; exp_y = 0; fill_mode = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin
      @(negedge vclock);
      n++;
    end
    if (!rx_ready) begin
      total++;
      $error("FAIL send_timeout: byte %0h never accepted (observed rx_ready 0, expected 1)", b);
    end
    @(negedge vclock);
    rx_valid = 1'b0;
  endtask

  task automatic csum(input logic [7:0] c);
`ifdef CELL_CMD_CHECKSUM_EN
    send(c);
`else
    if (c == 8'hxx) send(c);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge vclock);
  endtask

  initial begin
    prev_en = 1'b0; px = '0; py = '0; prgb = '0; exp_rgb = '0;
    clear_mon();
    #12;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_outputs", {cell_en, update, busy, err}, 0);
    check("rst_cell_data", {cell_x, cell_y, cell_rgb}, 0);
    check("rst_err_count", err_count, 0);
    @(negedge vclock);
    reset_n = 1'b1;
    idle(2);
    check("post_rst_rx_ready", rx_ready, 1);

    // SET (3,2) = F08
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h03); send(8'h02); send(8'h0F); send(8'h00); send(8'h08);
    csum(8'h07);
    idle(4);
    check("set_en_count", en_cnt, 1);
    check("set_stable", unstable, 0);
    check("set_no_double", dbl, 0);
    check("set_err", err_pulses, 0);
    check("set_busy_cycles", busy_cnt, 2);
    check("set_cell", {cell_x, cell_y, cell_rgb}, {4'd3, 4'd2, 12'hF08});

    // UPDATE with gaps on rx_valid
    clear_mon();
    send(8'hA5); idle(3); send(8'h02); idle(2);
    csum(8'h02);
    idle(5);
    check("upd_count", upd_cnt, 1);
    check("upd_no_en", en_cnt, 0);
    check("upd_busy_cycles", busy_cnt, 1);

    // FILL with 123
    clear_mon();
    fill_mode = 1'b1; exp_rgb = 12'h123;
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
    csum(8'h03);
    idle(400);
    check("fill_en_count", en_cnt, 192);
    check("fill_order_rgb", order_bad, 0);
    check("fill_busy_cycles", busy_cnt, 384);
    check("fill_rdy_low", rdy_bad, 0);
    check("fill_no_double", dbl, 0);
    check("fill_stable", unstable, 0);
    check("fill_last_cell", {cell_x, cell_y}, {4'd15, 4'd11});
    check("fill_err", err_pulses, 0);

    // SET out of range x=16
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h10); send(8'h00); send(8'h0F); send(8'h0F); send(8'h0F);
    csum(8'h1E);
    idle(3);
    check("range_no_en", en_cnt, 0);
    check("range_err_pulse", err_pulses, 1);
    check("range_err_count", err_count, 1);

    // unknown opcode
    send(8'hA5); send(8'h07); idle(2);
    check("badop_err_count", err_count, 2);

    // saturation
    for (int i = 0; i < 252; i++) begin send(8'hA5); send(8'h07); end
    idle(2);
    check("sat_254", err_count, 254);
    send(8'hA5); send(8'h07); idle(2);
    check("sat_255", err_count, 255);
    for (int i = 0; i < 3; i++) begin send(8'hA5); send(8'h07); end
    idle(2);
    check("sat_hold", err_count, 255);

    // resync through junk bytes
    clear_mon();
    send(8'h00); send(8'hFF); send(8'h5A); send(8'hA5); send(8'h02);
    csum(8'h02);
    idle(3);
    check("resync_upd", upd_cnt, 1);
    check("resync_no_err", err_pulses, 0);

`ifdef CELL_CMD_CHECKSUM_EN
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h00); idle(3);
    check("csum_bad_err", err_pulses, 1);
    check("csum_bad_no_upd", upd_cnt, 0);
`endif

    // reset during FILL
    clear_mon();
    fill_mode = 1'b1; exp_rgb = 12'h567;
    send(8'hA5); send(8'h03); send(8'h05); send(8'h06); send(8'h07);
    csum(8'h07);
    for (int i = 0; i < 1000 && en_cnt < 50; i++) @(negedge vclock);
    check("rstfill_reached_50", en_cnt >= 50, 1);
    reset_n = 1'b0;
    #1;
    check("rstfill_outputs", {cell_en, update, busy, err, rx_ready}, 0);
    check("rstfill_cell_data", {cell_x, cell_y, cell_rgb}, 0);
    check("rstfill_err_count", err_count, 0);
    idle(3);
    reset_n = 1'b1;
    clear_mon();
    idle(2);
    check("rstfill_rx_ready", rx_ready, 1);
    idle(400);
    check("rstfill_no_en", en_cnt, 0);
    check("rstfill_no_busy", busy_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
